can_rx_msgbuf: RTL and testbench

Parametrised receive message buffer for the CAN controller: it captures one frame at a time from the receive control unit and runs acceptance filtering on it. Accepted frames are pushed into a first-word-fall-through FIFO that the register interface drains. It supersedes the fixed 20-filter, fixed-depth receive FIFO and adds:
- configurable filter count and depth;
- a serial filter scan;
- frame abort;
- a distinct "accept-all" match index.

---
 rtl/can_rx_pkg.sv | 33 +++
 rtl/can_rx_filter_match.sv | 23 ++
 rtl/can_rx_msgbuf.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_can_rx_msgbuf.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/can_rx_pkg.sv
// ----------------------------------------------------------------------------
// can_rx_pkg
// Shared types and constants for the CAN receive message buffer:
//   - state_t : receive FSM states
//   - entry_t : one FIFO entry (frame fields, match index, 8 payload bytes)
//   - ID_W / KEY_W / MAX_BYTES : identifier, filter key and payload sizes
// ----------------------------------------------------------------------------
package can_rx_pkg;

  localparam int unsigned ID_W      = 29;
  localparam int unsigned KEY_W     = 31;  // {EXT, RTR, ID}
  localparam int unsigned MAX_BYTES = 8;
  // Widest match index: NUM_FILTERS is at most 32, so indices 0..32 fit in 6 bits
  localparam int unsigned FMI_MAX_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_HOLD,
    ST_PEND,
    ST_COMMIT
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]           id;
    logic                      rtr;
    logic                      ext;
    logic [3:0]                pkt_size;
    logic [FMI_MAX_W-1:0]      fmi;
    logic [MAX_BYTES-1:0][7:0] data;  // byte k at data[k]
  } entry_t;

endpackage

// File: rtl/can_rx_filter_match.sv
// ----------------------------------------------------------------------------
// can_rx_filter_match
// Compares one candidate key against one filter/mask pair.
// Ports:
//   i_en       filter enable
//   i_key      candidate key {EXT, RTR, ID}
//   i_filter   filter value, same layout as the key
//   i_mask     1 = bit must match, 0 = don't care
//   o_match_c  combinational match result
// ----------------------------------------------------------------------------
module can_rx_filter_match
  import can_rx_pkg::*;
(
  input  logic             i_en,
  input  logic [KEY_W-1:0] i_key,
  input  logic [KEY_W-1:0] i_filter,
  input  logic [KEY_W-1:0] i_mask,
  output logic             o_match_c
);

  assign o_match_c = i_en && (((i_key ^ i_filter) & i_mask) == '0);

endmodule

// File: rtl/can_rx_msgbuf.sv
// ----------------------------------------------------------------------------
// can_rx_msgbuf
// Receive message buffer: stages one frame from the receive control unit,
// runs acceptance filtering on it and pushes accepted frames into a
// first-word-fall-through FIFO drained by the register interface.
//
// Build option: CAN_RX_PARALLEL_FILTER_EN
//   defined   - all filters compared at once, priority encoder, 1-cycle scan
//   undefined - serial scan, one comparator stepped by a counter
//
// Ports:
//   clk, RST              clock, synchronous active-high reset
//   clear                 flush FIFO and clear overrun
//   new_ID/ID/RTR/EXT     start of frame and its identifier fields
//   data/data_index/load_data   payload byte write into staging
//   pkt_size              DLC of the current frame
//   pkt_done/pkt_abort    frame completed / frame discarded
//   enable_overrun        1 = overwrite oldest entry when full
//   mask_enable, filter_flat, mask_flat   filter bank, {EXT,RTR,ID} per slot
//   read_fifo             pop head entry
//   occupancy/full/empty/overrun          FIFO status (overrun sticky)
//   data_L/data_H/ID_out/pkt_size_out/RTR_out/EXT_out/fmi_out   head entry
//   fifo_read             one-cycle pulse after an accepted pop
// ----------------------------------------------------------------------------
module can_rx_msgbuf
  import can_rx_pkg::*;
#(
  parameter  int unsigned NUM_FILTERS = 20,
  parameter  int unsigned DEPTH       = 8,
  localparam int unsigned FMI_W       = $clog2(NUM_FILTERS + 1),
  localparam int unsigned OCC_W       = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         clear,
  input  logic                         new_ID,
  input  logic [28:0]                  ID,
  input  logic                         RTR,
  input  logic                         EXT,
  input  logic [7:0]                   data,
  input  logic [3:0]                   data_index,
  input  logic                         load_data,
  input  logic [3:0]                   pkt_size,
  input  logic                         pkt_done,
  input  logic                         pkt_abort,
  input  logic                         enable_overrun,
  input  logic [NUM_FILTERS-1:0]       mask_enable,
  input  logic [KEY_W*NUM_FILTERS-1:0] filter_flat,
  input  logic [KEY_W*NUM_FILTERS-1:0] mask_flat,
  input  logic                         read_fifo,
  output logic [OCC_W-1:0]             occupancy,
  output logic                         full,
  output logic                         empty,
  output logic                         overrun,
  output logic [31:0]                  data_L,
  output logic [31:0]                  data_H,
  output logic [28:0]                  ID_out,
  output logic [3:0]                   pkt_size_out,
  output logic                         RTR_out,
  output logic                         EXT_out,
  output logic [FMI_W-1:0]             fmi_out,
  output logic                         fifo_read
);

  localparam int unsigned AW = $clog2(DEPTH);

  // ---------------------------------------------------------------- staging
  state_t                    r_state;
  logic [ID_W-1:0]           r_id;
  logic                      r_rtr;
  logic                      r_ext;
  logic [3:0]                r_size;
  logic [MAX_BYTES-1:0][7:0] r_data;
  logic                      r_accept;
  logic [FMI_W-1:0]          r_fmi;

  // Staging register: ID fields on new_ID, payload bytes on load_data
  always_ff @(posedge clk) begin
    if (RST) begin
      r_id   <= '0;
      r_rtr  <= 1'b0;
      r_ext  <= 1'b0;
      r_size <= '0;
      r_data <= '0;
    end else begin
      if (new_ID) begin
        r_id   <= ID;
        r_rtr  <= RTR;
        r_ext  <= EXT;
        r_size <= pkt_size;
        r_data <= '0;
      end else if (pkt_done && (r_state == ST_SCAN || r_state == ST_HOLD)) begin
        r_size <= pkt_size;
      end
      // Indices 8..15 are out of range and dropped
      if (load_data && !data_index[3]) begin
        r_data[data_index[2:0]] <= data;
      end
    end
  end

  // --------------------------------------------------------------- filtering
  logic [KEY_W-1:0] w_key;
  logic [KEY_W-1:0] w_filt [NUM_FILTERS];
  logic [KEY_W-1:0] w_mask [NUM_FILTERS];
  logic             w_hit;
  logic             w_last;
  logic [FMI_W-1:0] w_hit_idx;

  assign w_key = {r_ext, r_rtr, r_id};

  for (genvar i = 0; i < NUM_FILTERS; i++) begin : g_slice
    assign w_filt[i] = filter_flat[KEY_W*i +: KEY_W];
    assign w_mask[i] = mask_flat[KEY_W*i +: KEY_W];
  end

`ifdef CAN_RX_PARALLEL_FILTER_EN
  logic [NUM_FILTERS-1:0] w_match;

  for (genvar i = 0; i < NUM_FILTERS; i++) begin : g_match
    can_rx_filter_match u_match (
      .i_en      (mask_enable[i]),
      .i_key     (w_key),
      .i_filter  (w_filt[i]),
      .i_mask    (w_mask[i]),
      .o_match_c (w_match[i])
    );
  end

  // Lowest matching index wins: scan downward so the lowest one is kept
  always_comb begin
    w_hit     = |w_match;
    w_hit_idx = '0;
    for (int i = int'(NUM_FILTERS) - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_idx = FMI_W'(i);
    end
  end

  assign w_last = 1'b1;
`else
  localparam int unsigned IDX_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  logic [IDX_W-1:0] r_idx;

  can_rx_filter_match u_match (
    .i_en      (mask_enable[r_idx]),
    .i_key     (w_key),
    .i_filter  (w_filt[r_idx]),
    .i_mask    (w_mask[r_idx]),
    .o_match_c (w_hit)
  );

  assign w_hit_idx = FMI_W'(r_idx);
  assign w_last    = (r_idx == IDX_W'(NUM_FILTERS - 1));

  // Scan counter: restarts on every new frame, steps while the scan runs
  always_ff @(posedge clk) begin
    if (RST || new_ID) begin
      r_idx <= '0;
    end else if ((r_state == ST_SCAN || r_state == ST_PEND) && !w_hit && !w_last) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end
`endif

  // --------------------------------------------------------------------- FSM
  // PEND means pkt_done already seen, so the scan end goes straight to COMMIT
  logic w_done_seen;
  assign w_done_seen = pkt_done || (r_state == ST_PEND);

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_accept <= 1'b0;
      r_fmi    <= '0;
    end else if (new_ID) begin
      r_state  <= ST_SCAN;
      r_accept <= 1'b0;
      r_fmi    <= '0;
    end else if (pkt_abort && r_state != ST_COMMIT) begin
      r_state  <= ST_IDLE;
      r_accept <= 1'b0;
    end else begin
      case (r_state)
        ST_SCAN, ST_PEND: begin
          if (w_hit || w_last) begin
            // No enabled filter at all means accept-all with a distinct index
            r_accept <= w_hit || (mask_enable == '0);
            r_fmi    <= w_hit ? w_hit_idx : FMI_W'(NUM_FILTERS);
            r_state  <= w_done_seen ? ST_COMMIT : ST_HOLD;
          end else begin
            r_state  <= w_done_seen ? ST_PEND : ST_SCAN;
          end
        end
        ST_HOLD: begin
          if (pkt_done) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------- FIFO
  entry_t           r_mem [DEPTH];
  entry_t           r_head;
  entry_t           w_entry;
  entry_t           w_head_nxt;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_overrun;
  logic             r_fifo_read;

  logic             w_push;
  logic             w_pop;
  logic             w_is_full;
  logic             w_wen;
  logic             w_ovr_nxt;
  logic [AW-1:0]    w_wr_nxt;
  logic [AW-1:0]    w_rd_nxt;
  logic [OCC_W-1:0] w_cnt_nxt;

  always_comb begin
    w_entry          = '0;
    w_entry.id       = r_id;
    w_entry.rtr      = r_rtr;
    w_entry.ext      = r_ext;
    w_entry.pkt_size = r_size;
    w_entry.fmi      = FMI_MAX_W'(r_fmi);
    w_entry.data     = r_data;
  end

  // A same-cycle new_ID or clear drops the frame being committed
  assign w_push    = (r_state == ST_COMMIT) && r_accept && !new_ID && !clear;
  assign w_pop     = read_fifo && (r_count != '0) && !clear;
  assign w_is_full = (r_count == OCC_W'(DEPTH));

  // Next pointers/count; full + push without pop either evicts or drops
  always_comb begin
    w_wen     = 1'b0;
    w_ovr_nxt = r_overrun;
    w_wr_nxt  = r_wr_ptr;
    w_rd_nxt  = r_rd_ptr;
    w_cnt_nxt = r_count;
    if (w_push) begin
      if (!w_is_full || w_pop) begin
        w_wen    = 1'b1;
        w_wr_nxt = r_wr_ptr + AW'(1);
        if (!w_pop) w_cnt_nxt = r_count + OCC_W'(1);
      end else if (enable_overrun) begin
        w_wen     = 1'b1;
        w_wr_nxt  = r_wr_ptr + AW'(1);
        w_rd_nxt  = r_rd_ptr + AW'(1);
        w_ovr_nxt = 1'b1;
      end else begin
        w_ovr_nxt = 1'b1;
      end
    end
    if (w_pop) begin
      w_rd_nxt = r_rd_ptr + AW'(1);
      if (!w_wen) w_cnt_nxt = r_count - OCC_W'(1);
    end
    if (clear) begin
      w_wr_nxt  = '0;
      w_rd_nxt  = '0;
      w_cnt_nxt = '0;
      w_ovr_nxt = 1'b0;
    end
  end

  // Next head: bypass the entry being written when it lands in the head slot
  always_comb begin
    if (w_cnt_nxt == '0) begin
      w_head_nxt = '0;
    end else if (w_wen && (r_wr_ptr == w_rd_nxt)) begin
      w_head_nxt = w_entry;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  // Entry storage, no reset needed: only read when occupancy says valid
  always_ff @(posedge clk) begin
    if (w_wen) r_mem[r_wr_ptr] <= w_entry;
  end

  // FIFO state and registered head/status
  always_ff @(posedge clk) begin
    if (RST) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_overrun   <= 1'b0;
      r_fifo_read <= 1'b0;
      r_head      <= '0;
    end else begin
      r_wr_ptr    <= w_wr_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_count     <= w_cnt_nxt;
      r_full      <= (w_cnt_nxt == OCC_W'(DEPTH));
      r_empty     <= (w_cnt_nxt == '0);
      r_overrun   <= w_ovr_nxt;
      r_fifo_read <= w_pop;
      r_head      <= w_head_nxt;
    end
  end

  assign occupancy    = r_count;
  assign full         = r_full;
  assign empty        = r_empty;
  assign overrun      = r_overrun;
  assign fifo_read    = r_fifo_read;
  assign data_L       = r_head.data[3:0];
  assign data_H       = r_head.data[7:4];
  assign ID_out       = r_head.id;
  assign pkt_size_out = r_head.pkt_size;
  assign RTR_out      = r_head.rtr;
  assign EXT_out      = r_head.ext;
  assign fmi_out      = FMI_W'(r_head.fmi);

endmodule

// File: tb/tb_can_rx_msgbuf.sv
// Directed bench for can_rx_msgbuf (NUM_FILTERS=20, DEPTH=4).
module tb_can_rx_msgbuf;

  localparam int unsigned NF = 20;
  localparam int unsigned DP = 4;

  logic            clk;
  logic            RST, clear, new_ID, RTR, EXT, load_data, pkt_done, pkt_abort;
  logic [28:0]     ID;
  logic [7:0]      data;
  logic [3:0]      data_index, pkt_size;
  logic            enable_overrun, read_fifo;
  logic [NF-1:0]   mask_enable;
  logic [31*NF-1:0] filter_flat, mask_flat;
  logic [2:0]      occupancy;
  logic            full, empty, overrun, RTR_out, EXT_out, fifo_read;
  logic [31:0]     data_L, data_H;
  logic [28:0]     ID_out;
  logic [3:0]      pkt_size_out;
  logic [4:0]      fmi_out;

  int n_cmp = 0;
  int n_err = 0;

  can_rx_msgbuf #(.NUM_FILTERS(NF), .DEPTH(DP)) dut (
    .clk(clk), .RST(RST), .clear(clear), .new_ID(new_ID), .ID(ID), .RTR(RTR), .EXT(EXT),
    .data(data), .data_index(data_index), .load_data(load_data), .pkt_size(pkt_size),
    .pkt_done(pkt_done), .pkt_abort(pkt_abort), .enable_overrun(enable_overrun),
    .mask_enable(mask_enable), .filter_flat(filter_flat), .mask_flat(mask_flat),
    .read_fifo(read_fifo), .occupancy(occupancy), .full(full), .empty(empty),
    .overrun(overrun), .data_L(data_L), .data_H(data_H), .ID_out(ID_out),
    .pkt_size_out(pkt_size_out), .RTR_out(RTR_out), .EXT_out(EXT_out),
    .fmi_out(fmi_out), .fifo_read(fifo_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_filter(input int i, input logic [30:0] f, input logic [30:0] m);
    filter_flat[31*i +: 31] = f;
    mask_flat[31*i +: 31]   = m;
  endtask

  // new_ID, two payload bytes, pkt_done on consecutive cycles; returns 4 cycles after new_ID
  task automatic send_frame(input logic [28:0] id, input logic rtr, input logic ext,
                            input logic [3:0] dlc, input logic [7:0] b0, input logic [7:0] b1);
    new_ID = 1'b1; ID = id; RTR = rtr; EXT = ext; pkt_size = dlc;
    tick(); new_ID = 1'b0;
    load_data = 1'b1; data = b0; data_index = 4'd0;
    tick();
    data = b1; data_index = 4'd1;
    tick(); load_data = 1'b0;
    pkt_done = 1'b1;
    tick(); pkt_done = 1'b0;
  endtask

  task automatic pop_one();
    read_fifo = 1'b1;
    tick(); read_fifo = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(); clear = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; clear = 0; new_ID = 0; ID = 0; RTR = 0; EXT = 0; data = 0; data_index = 0;
    load_data = 0; pkt_size = 0; pkt_done = 0; pkt_abort = 0; enable_overrun = 0;
    mask_enable = '0; filter_flat = '0; mask_flat = '0; read_fifo = 0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    n_cmp++; if ({occupancy, full, empty, overrun, fifo_read} !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_status: got occ=%0d full=%b empty=%b ovr=%b rd=%b want 0 0 1 0 0", occupancy, full, empty, overrun, fifo_read); end
    n_cmp++; if ({ID_out, pkt_size_out, RTR_out, EXT_out, fmi_out, data_L, data_H} !== '0) begin
      n_err++; $display("FAIL reset_head: got id=%h fmi=%0d dL=%h dH=%h want all zero", ID_out, fmi_out, data_L, data_H); end
    // reset mid-frame (accept-all) discards the frame; later pkt_done lands in IDLE
    new_ID = 1'b1; ID = 29'h0AA; pkt_size = 4'd1;
    tick(); new_ID = 1'b0;
    RST = 1'b1;
    tick(); RST = 1'b0;
    pkt_done = 1'b1;
    tick(); pkt_done = 1'b0;
    repeat (30) tick();
    n_cmp++; if (occupancy !== 3'd0) begin
      n_err++; $display("FAIL reset_midframe: got occ=%0d want 0", occupancy); end
  endtask

  task automatic test_filter_hit();
    set_filter(3, 31'h123, 31'h7FF);
    mask_enable = 20'h00008;
    send_frame(29'h123, 1'b0, 1'b0, 4'd2, 8'hAA, 8'hBB);
    tick();  // 5 cycles after new_ID edge minus one: not yet visible
    n_cmp++; if (occupancy !== 3'd0) begin
      n_err++; $display("FAIL hit_latency_early: got occ=%0d want 0", occupancy); end
    tick();
    n_cmp++; if (occupancy !== 3'd1 || empty !== 1'b0) begin
      n_err++; $display("FAIL hit_occ: got occ=%0d empty=%b want 1 0", occupancy, empty); end
    n_cmp++; if (fmi_out !== 5'd3) begin
      n_err++; $display("FAIL hit_fmi: got %0d want 3", fmi_out); end
    n_cmp++; if (data_L !== 32'h0000BBAA || data_H !== 32'h0) begin
      n_err++; $display("FAIL hit_data: got %h_%h want 00000000_0000bbaa", data_H, data_L); end
    n_cmp++; if (ID_out !== 29'h123 || pkt_size_out !== 4'd2) begin
      n_err++; $display("FAIL hit_fields: got id=%h dlc=%0d want 123 2", ID_out, pkt_size_out); end
    pop_one();
    n_cmp++; if ({fifo_read, empty, occupancy} !== {1'b1, 1'b1, 3'd0} || ID_out !== 29'h0 || data_L !== 32'h0) begin
      n_err++; $display("FAIL hit_pop: got rd=%b empty=%b occ=%0d id=%h dL=%h want 1 1 0 0 0", fifo_read, empty, occupancy, ID_out, data_L); end
    tick();
    n_cmp++; if (fifo_read !== 1'b0) begin
      n_err++; $display("FAIL hit_pop_pulse: got %b want 0", fifo_read); end
    pop_one();  // read while empty is ignored
    n_cmp++; if (fifo_read !== 1'b0 || occupancy !== 3'd0) begin
      n_err++; $display("FAIL empty_read: got rd=%b occ=%0d want 0 0", fifo_read, occupancy); end
  endtask

  task automatic test_priority();
    set_filter(5, 31'h120, 31'h7F0);
    mask_enable = 20'h00028;  // filters 3 and 5
    send_frame(29'h123, 1'b0, 1'b0, 4'd1, 8'h01, 8'h00);
    repeat (8) tick();
    n_cmp++; if (fmi_out !== 5'd3 || occupancy !== 3'd1) begin
      n_err++; $display("FAIL prio_lowest: got fmi=%0d occ=%0d want 3 1", fmi_out, occupancy); end
    pop_one();
    send_frame(29'h12F, 1'b0, 1'b0, 4'd1, 8'h02, 8'h00);
    repeat (8) tick();
    n_cmp++; if (fmi_out !== 5'd5 || ID_out !== 29'h12F) begin
      n_err++; $display("FAIL prio_mask_dc: got fmi=%0d id=%h want 5 12f", fmi_out, ID_out); end
    pop_one();
  endtask

  task automatic test_accept_all();
    mask_enable = '0;
    send_frame(29'h1ABCDE01, 1'b1, 1'b1, 4'd8, 8'h11, 8'h22);
    repeat (22) tick();
    n_cmp++; if (fmi_out !== 5'd20 || occupancy !== 3'd1) begin
      n_err++; $display("FAIL accall_fmi: got fmi=%0d occ=%0d want 20 1", fmi_out, occupancy); end
    n_cmp++; if ({ID_out, RTR_out, EXT_out, pkt_size_out} !== {29'h1ABCDE01, 1'b1, 1'b1, 4'd8} || data_L !== 32'h00002211) begin
      n_err++; $display("FAIL accall_fields: got id=%h rtr=%b ext=%b dlc=%0d dL=%h want 1abcde01 1 1 8 00002211", ID_out, RTR_out, EXT_out, pkt_size_out, data_L); end
    pop_one();
  endtask

  task automatic test_reject();
    set_filter(0, 31'h100, 31'h7FF);
    mask_enable = 20'h00001;
    send_frame(29'h200, 1'b0, 1'b0, 4'd1, 8'h55, 8'h00);
    repeat (25) tick();
    n_cmp++; if (occupancy !== 3'd0 || empty !== 1'b1) begin
      n_err++; $display("FAIL reject_id: got occ=%0d empty=%b want 0 1", occupancy, empty); end
    // EXT bit is compared: extended frame with a standard-only filter is rejected
    set_filter(3, 31'h123, 31'h400007FF);
    mask_enable = 20'h00008;
    send_frame(29'h123, 1'b0, 1'b1, 4'd1, 8'h55, 8'h00);
    repeat (25) tick();
    n_cmp++; if (occupancy !== 3'd0) begin
      n_err++; $display("FAIL reject_ext: got occ=%0d want 0", occupancy); end
  endtask

  task automatic test_abort();
    mask_enable = '0;
    new_ID = 1'b1; ID = 29'h33; RTR = 0; EXT = 0; pkt_size = 4'd1;
    tick(); new_ID = 1'b0;
    load_data = 1'b1; data = 8'hEE; data_index = 4'd0;
    tick(); load_data = 1'b0;
    pkt_abort = 1'b1;
    tick(); pkt_abort = 1'b0;
    pkt_done = 1'b1;
    tick(); pkt_done = 1'b0;
    repeat (25) tick();
    n_cmp++; if (occupancy !== 3'd0) begin
      n_err++; $display("FAIL abort_drop: got occ=%0d want 0", occupancy); end
    send_frame(29'h77, 1'b0, 1'b0, 4'd2, 8'h01, 8'h02);
    repeat (22) tick();
    n_cmp++; if (occupancy !== 3'd1 || ID_out !== 29'h77 || data_L !== 32'h00000201) begin
      n_err++; $display("FAIL abort_next: got occ=%0d id=%h dL=%h want 1 77 00000201", occupancy, ID_out, data_L); end
    pop_one();
  endtask

  task automatic test_overrun();
    set_filter(0, 31'h0, 31'h0);  // filter 0 matches everything, fast commit
    mask_enable = 20'h00001;
    pulse_clear();
    enable_overrun = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      send_frame(29'(i), 1'b0, 1'b0, 4'd1, 8'(i), 8'h00);
      repeat (3) tick();
    end
    n_cmp++; if ({occupancy, full, overrun} !== {3'd4, 1'b1, 1'b1} || ID_out !== 29'd2) begin
      n_err++; $display("FAIL ovr_on: got occ=%0d full=%b ovr=%b id=%0d want 4 1 1 2", occupancy, full, overrun, ID_out); end
    pulse_clear();
    n_cmp++; if ({occupancy, full, empty, overrun} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL ovr_clear: got occ=%0d full=%b empty=%b ovr=%b want 0 0 1 0", occupancy, full, empty, overrun); end
    enable_overrun = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(29'(i), 1'b0, 1'b0, 4'd1, 8'(i), 8'h00);
      repeat (3) tick();
    end
    n_cmp++; if ({occupancy, overrun} !== {3'd4, 1'b1} || ID_out !== 29'd1) begin
      n_err++; $display("FAIL ovr_off: got occ=%0d ovr=%b id=%0d want 4 1 1", occupancy, overrun, ID_out); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (ID_out !== 29'(i)) begin
        n_err++; $display("FAIL ovr_off_order: got id=%0d want %0d", ID_out, i); end
      pop_one();
    end
    n_cmp++; if (empty !== 1'b1 || overrun !== 1'b1) begin
      n_err++; $display("FAIL ovr_off_drain: got empty=%b ovr=%b want 1 1", empty, overrun); end
    pulse_clear();
  endtask

  task automatic test_full_push_pop();
    enable_overrun = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send_frame(29'(i), 1'b0, 1'b0, 4'd1, 8'(i), 8'h00);
      repeat (3) tick();
    end
    n_cmp++; if ({full, overrun} !== {1'b1, 1'b0}) begin
      n_err++; $display("FAIL pp_fill: got full=%b ovr=%b want 1 0", full, overrun); end
    send_frame(29'd9, 1'b0, 1'b0, 4'd1, 8'h09, 8'h00);
    read_fifo = 1'b1;  // lands on the COMMIT edge
    tick(); read_fifo = 1'b0;
    n_cmp++; if ({occupancy, overrun, fifo_read} !== {3'd4, 1'b0, 1'b1} || ID_out !== 29'd2) begin
      n_err++; $display("FAIL pp_same_cycle: got occ=%0d ovr=%b rd=%b id=%0d want 4 0 1 2", occupancy, overrun, fifo_read, ID_out); end
    tick();
    n_cmp++; if (fifo_read !== 1'b0) begin
      n_err++; $display("FAIL pp_pulse_once: got %b want 0", fifo_read); end
    for (int i = 0; i < 4; i++) begin
      logic [28:0] exp_id;
      exp_id = (i == 3) ? 29'd9 : 29'(i + 2);
      n_cmp++; if (ID_out !== exp_id) begin
        n_err++; $display("FAIL pp_order: got id=%0d want %0d", ID_out, exp_id); end
      pop_one();
    end
  endtask

  initial begin
    test_reset();
    test_filter_hit();
    test_priority();
    test_accept_all();
    test_reject();
    test_abort();
    test_overrun();
    test_full_push_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
